input_conditioner: RTL and testbench
====================================

// Module: input_conditioner
// PURPOSE
//  Conditions raw GPIO inputs from the board (10 reed-sensor lines, 4 boundary
//  limit switches) before motorMain, sensor_scan and encoding consume them.
//  Per channel: 2-flop synchroniser, counter-based debounce, rise/fall pulses.
//  A req/ack snapshot port hands a coherent, frozen copy of all channels to a consumer.
// PARAMETERS
//  N_CH             14     number of input channels: [9:0] sensors, [13:10] N,S,W,E limits
//  DEBOUNCE_CYCLES  50000  consecutive stable cycles required to accept a change (1 ms @ 50 MHz)
//  CNT_W            16     debounce counter width; must hold DEBOUNCE_CYCLES-1
//  ACTIVE_LOW       1      1: raw pin low = asserted (input inverted after sync)
// PORTS
//  clk           in   1     50 MHz system clock (CLOCK_50)
//  rst_n         in   1     asynchronous active-low reset
//  raw_in        in   N_CH  unsynchronised GPIO levels
//  stable_out    out  N_CH  debounced, asserted-high levels
//  rise_pulse    out  N_CH  1-cycle pulse when stable_out bit goes 0->1
//  fall_pulse    out  N_CH  1-cycle pulse when stable_out bit goes 1->0
//  snap_req      in   1     level request for a snapshot
//  snap_ack      out  1     high while snap_data/snap_changed are valid and frozen
//  snap_data     out  N_CH  stable_out captured at snapshot
//  snap_changed  out  N_CH  per-channel sticky: any stable edge since previous snapshot
// BEHAVIOUR
//  Reset values: sync flops = inactive pin level (1 if ACTIVE_LOW, else 0);
//   counters 0; stable_out, rise/fall pulses, snap_ack, snap_data, snap_changed
//   and sticky bits all 0; FSM = IDLE. Reset mid-debounce discards the pending count.
//  Sync: two flops per channel; s = sync2 ^ ACTIVE_LOW (asserted-high).
//  Debounce, per channel, every cycle:
//   - s == stable: counter <= 0.
//   - s != stable, counter <  DEBOUNCE_CYCLES-1: counter <= counter+1.
//   - s != stable, counter == DEBOUNCE_CYCLES-1: stable <= s, counter <= 0,
//     pulse asserted in the same cycle stable_out changes.
//   - DEBOUNCE_CYCLES==1: flips on the first mismatching cycle.
//   - Glitch shorter than DEBOUNCE_CYCLES: no output change, counter restarts.
//  Latency: raw edge -> stable_out change = 2 + DEBOUNCE_CYCLES clock edges.
//  Pulses: registered, exactly 1 cycle; never rise and fall on one bit in one cycle.
//  Sticky: set by any rise/fall pulse on that bit; cleared only on snapshot capture.
//  Snapshot FSM (IDLE, HOLD):
//   IDLE: snap_ack=0. On snap_req=1: snap_data <= stable_out,
//     snap_changed <= sticky, sticky <= pulses this cycle (edge coincident with
//     capture is kept for the NEXT snapshot, never lost); -> HOLD.
//   HOLD: snap_ack=1, snap_data/snap_changed frozen. On snap_req=0 -> IDLE
//     (ack falls next cycle). snap_req held high keeps HOLD indefinitely.
//   Consumer must drop snap_req after seeing ack before requesting again;
//   a new capture requires one IDLE cycle.
//  Debounce runs independently of snapshot state; edges during HOLD accumulate
//  in sticky.
// STRUCTURE
//  defines.v: channel index constants (CH_SENSOR0..9, CH_LIMIT_N/S/W/E) and
//   default DEBOUNCE_CYCLES; shared with MainTest wiring.
//  Sub-module debounce_channel (sync2 + counter + stable + rise/fall), generated
//   N_CH times; snapshot FSM and sticky logic in input_conditioner.
//  Replaces the per-line shift instances in the top level.
// TESTING (DEBOUNCE_CYCLES=8 for sim)
//  Reset with raw_in all 1 (ACTIVE_LOW) -> stable_out=0, no pulses, snap_ack=0.
//  raw_in[3] 1->0 and held -> stable_out[3]=1 exactly 10 cycles later, rise_pulse[3] 1 cycle.
//  raw_in[5] low for 7 cycles then high -> stable_out[5] stays 0, no pulse.
//  Toggle ch0 (debounced), then snap_req=1 -> snap_ack next cycle, snap_data[0]=1,
//   snap_changed=14'h0001; drop req -> ack 0; repeat req -> snap_changed=0.
//  Fall pulse on ch12 in the capture cycle -> absent from this snapshot, present in next.
//  rst_n low for 1 cycle while ch7 counter=5 -> counter cleared, change needs full 10 cycles.

Source files
------------

// File: rtl/input_conditioner_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : input_conditioner_pkg
//  Purpose  : Shared constants and types for the GPIO input conditioner:
//             channel map, default debounce timing and snapshot FSM states.
//  Revision : 1.0 - initial release
// ============================================================================
package input_conditioner_pkg;

    // Channel map: reed sensors in the low bits, boundary limit switches above
    localparam int c_n_ch                    = 14;
    localparam int c_ch_sensor0              = 0;
    localparam int c_ch_sensor9              = 9;
    localparam int c_ch_limit_n              = 10;
    localparam int c_ch_limit_s              = 11;
    localparam int c_ch_limit_w              = 12;
    localparam int c_ch_limit_e              = 13;

    // 1 ms at 50 MHz
    localparam int c_debounce_cycles_default = 50000;
    localparam int c_cnt_w_default           = 16;

    // Snapshot handshake states
    typedef enum logic [0:0] {
        SNAP_IDLE = 1'b0,
        SNAP_HOLD = 1'b1
    } snap_state_t;

endpackage : input_conditioner_pkg
`default_nettype wire

// File: rtl/input_conditioner_debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_channel
//  Purpose  : One conditioned input line: 2-flop synchroniser, polarity
//             normalisation, counter debounce and registered edge pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_debounce_cycles_default,
    parameter int CNT_W           = c_cnt_w_default,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             w_s;

    // Asserted-high view of the synchronised pin
    assign w_s = r_sync2 ^ ACTIVE_LOW;

    // Two-flop synchroniser, reset to the inactive pin level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= ACTIVE_LOW;
            r_sync2 <= ACTIVE_LOW;
        end else begin
            r_sync1 <= raw;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES consecutive mismatches;
    // the edge pulse is raised on the same edge that stable changes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            stable <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (w_s == stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_max) begin
                stable <= w_s;
                r_cnt  <= '0;
                rise   <= w_s;
                fall   <= ~w_s;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule : debounce_channel
`default_nettype wire

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : input_conditioner
//  Purpose  : Debounces all GPIO input channels and offers a req/ack snapshot
//             port returning a frozen, coherent copy of the debounced levels
//             plus per-channel "changed since last snapshot" flags.
//  Revision : 1.0 - initial release
// ============================================================================
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int N_CH            = c_n_ch,
    parameter int DEBOUNCE_CYCLES = c_debounce_cycles_default,
    parameter int CNT_W           = c_cnt_w_default,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] stable_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse,
    input  logic            snap_req,
    output logic            snap_ack,
    output logic [N_CH-1:0] snap_data,
    output logic [N_CH-1:0] snap_changed
);

    snap_state_t     r_state;
    logic [N_CH-1:0] r_sticky;
    logic [N_CH-1:0] w_pulse;

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            debounce_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W),
                .ACTIVE_LOW      (ACTIVE_LOW)
            ) u_debounce (
                .clk    (clk),
                .rst_n  (rst_n),
                .raw    (raw_in[gi]),
                .stable (stable_out[gi]),
                .rise   (rise_pulse[gi]),
                .fall   (fall_pulse[gi])
            );
        end
    endgenerate

    assign w_pulse = rise_pulse | fall_pulse;

    // Snapshot handshake; a pulse coincident with capture seeds the next
    // sticky set so no edge is ever dropped between snapshots
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= SNAP_IDLE;
            r_sticky     <= '0;
            snap_ack     <= 1'b0;
            snap_data    <= '0;
            snap_changed <= '0;
        end else begin
            case (r_state)
                SNAP_IDLE: begin
                    if (snap_req) begin
                        snap_data    <= stable_out;
                        snap_changed <= r_sticky;
                        r_sticky     <= w_pulse;
                        snap_ack     <= 1'b1;
                        r_state      <= SNAP_HOLD;
                    end else begin
                        r_sticky <= r_sticky | w_pulse;
                    end
                end
                SNAP_HOLD: begin
                    r_sticky <= r_sticky | w_pulse;
                    if (!snap_req) begin
                        snap_ack <= 1'b0;
                        r_state  <= SNAP_IDLE;
                    end
                end
                default: begin
                    snap_ack <= 1'b0;
                    r_state  <= SNAP_IDLE;
                end
            endcase
        end
    end

endmodule : input_conditioner
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_input_conditioner
//  Purpose  : Self-checking bench for input_conditioner (DEBOUNCE_CYCLES=8)
//             with directed scenarios and a randomized run against a
//             window-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_input_conditioner;

    localparam int N  = 14;
    localparam int DC = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] raw_in = '1;
    logic         snap_req = 1'b0;
    logic [N-1:0] stable_out, rise_pulse, fall_pulse, snap_data, snap_changed;
    logic         snap_ack;

    int n_checks = 0;
    int n_pass   = 0;
    logic [N-1:0] cur_raw = '1;

    input_conditioner #(
        .N_CH            (N),
        .DEBOUNCE_CYCLES (DC),
        .CNT_W           (16),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .raw_in       (raw_in),
        .stable_out   (stable_out),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .snap_req     (snap_req),
        .snap_ack     (snap_ack),
        .snap_data    (snap_data),
        .snap_changed (snap_changed)
    );

    always #5 clk = ~clk;

    // Reference model: a level is accepted once the asserted-high pin value
    // seen by the core (pin delayed two edges) has differed from the current
    // level in each of the last DC samples.
    logic [N-1:0] raw_q[$];
    logic [N-1:0] s_win[$];
    logic [N-1:0] m_stable, m_rise, m_fall, m_sticky, m_data, m_changed;
    logic         m_ack, m_hold;

    task automatic model_reset();
        raw_q.delete();
        s_win.delete();
        repeat (2) raw_q.push_back('1);
        repeat (DC) s_win.push_back('0);
        m_stable = '0; m_rise = '0; m_fall = '0; m_sticky = '0;
        m_data = '0; m_changed = '0; m_ack = 1'b0; m_hold = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] raw, input logic req);
        logic [N-1:0] s_now, old_stable, old_pulse, flip;
        s_now = ~raw_q[0];
        void'(raw_q.pop_front());
        raw_q.push_back(raw);
        s_win.push_back(s_now);
        void'(s_win.pop_front());
        old_stable = m_stable;
        old_pulse  = m_rise | m_fall;
        flip = '1;
        foreach (s_win[i]) flip &= s_win[i] ^ old_stable;
        if (!m_hold && req) begin
            m_data    = old_stable;
            m_changed = m_sticky;
            m_sticky  = old_pulse;
            m_ack     = 1'b1;
            m_hold    = 1'b1;
        end else begin
            m_sticky = m_sticky | old_pulse;
            if (m_hold && !req) begin
                m_ack  = 1'b0;
                m_hold = 1'b0;
            end
        end
        m_stable = old_stable ^ flip;
        m_rise   = flip & m_stable;
        m_fall   = flip & ~m_stable;
    endtask

    // One clock: drive at negedge, model at posedge, return at next negedge
    task automatic tick(input logic [N-1:0] raw, input logic req);
        raw_in   = raw;
        snap_req = req;
        @(posedge clk);
        model_step(raw, req);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        cur_raw  = '1;
        raw_in   = cur_raw;
        snap_req = 1'b0;
        @(negedge clk);
        do_reset();
        n_checks++; if (stable_out !== '0) $display("FAIL reset_stable: got %h want 0", stable_out); else n_pass++;
        n_checks++; if (rise_pulse !== '0) $display("FAIL reset_rise: got %h want 0", rise_pulse); else n_pass++;
        n_checks++; if (fall_pulse !== '0) $display("FAIL reset_fall: got %h want 0", fall_pulse); else n_pass++;
        n_checks++; if (snap_ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", snap_ack); else n_pass++;
        n_checks++; if (snap_data !== '0) $display("FAIL reset_snap_data: got %h want 0", snap_data); else n_pass++;
        n_checks++; if (snap_changed !== '0) $display("FAIL reset_snap_changed: got %h want 0", snap_changed); else n_pass++;
    endtask

    task automatic test_latency();
        cur_raw[3] = 1'b0;
        for (int i = 1; i <= 11; i++) begin
            tick(cur_raw, 1'b0);
            n_checks++;
            if (stable_out[3] !== (i >= 10))
                $display("FAIL latency_stable3 edge %0d: got %b want %b", i, stable_out[3], (i >= 10));
            else n_pass++;
            n_checks++;
            if (rise_pulse[3] !== (i == 10))
                $display("FAIL latency_rise3 edge %0d: got %b want %b", i, rise_pulse[3], (i == 10));
            else n_pass++;
        end
        cur_raw[3] = 1'b1;
        repeat (11) tick(cur_raw, 1'b0);
        n_checks++; if (stable_out[3] !== 1'b0) $display("FAIL release_stable3: got %b want 0", stable_out[3]); else n_pass++;
    endtask

    task automatic test_glitch();
        cur_raw[5] = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 8) cur_raw[5] = 1'b1;
            tick(cur_raw, 1'b0);
            n_checks++;
            if (stable_out[5] !== 1'b0 || rise_pulse[5] !== 1'b0 || fall_pulse[5] !== 1'b0)
                $display("FAIL glitch_ch5 edge %0d: got stable=%b rise=%b fall=%b want 0/0/0",
                         i, stable_out[5], rise_pulse[5], fall_pulse[5]);
            else n_pass++;
        end
    endtask

    task automatic test_snapshot();
        tick(cur_raw, 1'b1); tick(cur_raw, 1'b0); tick(cur_raw, 1'b0);
        cur_raw[0] = 1'b0;
        repeat (12) tick(cur_raw, 1'b0);
        tick(cur_raw, 1'b1);
        n_checks++; if (snap_ack !== 1'b1) $display("FAIL snap1_ack: got %b want 1", snap_ack); else n_pass++;
        n_checks++; if (snap_data[0] !== 1'b1) $display("FAIL snap1_data0: got %b want 1", snap_data[0]); else n_pass++;
        n_checks++; if (snap_changed !== 14'h0001) $display("FAIL snap1_changed: got %h want 0001", snap_changed); else n_pass++;
        repeat (3) tick(cur_raw, 1'b1);
        n_checks++;
        if (snap_ack !== 1'b1 || snap_changed !== 14'h0001)
            $display("FAIL snap1_hold: got ack=%b changed=%h want 1/0001", snap_ack, snap_changed);
        else n_pass++;
        tick(cur_raw, 1'b0);
        n_checks++; if (snap_ack !== 1'b0) $display("FAIL snap1_drop_ack: got %b want 0", snap_ack); else n_pass++;
        tick(cur_raw, 1'b0);
        tick(cur_raw, 1'b1);
        n_checks++; if (snap_ack !== 1'b1) $display("FAIL snap2_ack: got %b want 1", snap_ack); else n_pass++;
        n_checks++; if (snap_changed !== '0) $display("FAIL snap2_changed: got %h want 0", snap_changed); else n_pass++;
        tick(cur_raw, 1'b0); tick(cur_raw, 1'b0);
    endtask

    task automatic test_coincident();
        cur_raw[12] = 1'b0;
        repeat (12) tick(cur_raw, 1'b0);
        n_checks++; if (stable_out[12] !== 1'b1) $display("FAIL coin_assert12: got %b want 1", stable_out[12]); else n_pass++;
        tick(cur_raw, 1'b1); tick(cur_raw, 1'b0); tick(cur_raw, 1'b0);
        cur_raw[12] = 1'b1;
        repeat (10) tick(cur_raw, 1'b0);
        n_checks++; if (fall_pulse[12] !== 1'b1) $display("FAIL coin_fall12: got %b want 1", fall_pulse[12]); else n_pass++;
        tick(cur_raw, 1'b1);
        n_checks++; if (snap_ack !== 1'b1) $display("FAIL coin_ack: got %b want 1", snap_ack); else n_pass++;
        n_checks++; if (snap_changed[12] !== 1'b0) $display("FAIL coin_changed_now: got %b want 0", snap_changed[12]); else n_pass++;
        tick(cur_raw, 1'b0); tick(cur_raw, 1'b0);
        tick(cur_raw, 1'b1);
        n_checks++; if (snap_changed[12] !== 1'b1) $display("FAIL coin_changed_next: got %b want 1", snap_changed[12]); else n_pass++;
        tick(cur_raw, 1'b0); tick(cur_raw, 1'b0);
    endtask

    task automatic test_reset_mid();
        cur_raw[7] = 1'b0;
        repeat (7) tick(cur_raw, 1'b0);
        raw_in = cur_raw;
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            tick(cur_raw, 1'b0);
            n_checks++;
            if (stable_out[7] !== (i == 10))
                $display("FAIL reset_mid_ch7 edge %0d: got %b want %b", i, stable_out[7], (i == 10));
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic req;
        req = 1'b0;
        cur_raw = '1;
        raw_in  = cur_raw;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int ch = 0; ch < N; ch++)
                if ($urandom_range(0, 15) == 0) cur_raw[ch] = ~cur_raw[ch];
            if ($urandom_range(0, 5) == 0) req = ~req;
            tick(cur_raw, req);
            n_checks++;
            if (stable_out !== m_stable || rise_pulse !== m_rise || fall_pulse !== m_fall)
                $display("FAIL rand_levels cyc %0d: got s=%h r=%h f=%h want s=%h r=%h f=%h",
                         c, stable_out, rise_pulse, fall_pulse, m_stable, m_rise, m_fall);
            else n_pass++;
            n_checks++;
            if (snap_ack !== m_ack || snap_data !== m_data || snap_changed !== m_changed)
                $display("FAIL rand_snap cyc %0d: got ack=%b d=%h c=%h want ack=%b d=%h c=%h",
                         c, snap_ack, snap_data, snap_changed, m_ack, m_data, m_changed);
            else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_latency();
        test_glitch();
        test_snapshot();
        test_coincident();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_input_conditioner
`default_nettype wire
